// File: rtl/baud_gen_frac_pkg.sv
// baud_gen_frac_pkg: shared widths, oversampling ratio and reset divisor
package baud_gen_frac_pkg;
    localparam int DIV_INT_W    = 16;
    localparam int FRAC_W       = 4;
    localparam int OVERSAMPLE   = 16;
    localparam int DEF_DIV_INT  = 27;
    localparam int DEF_DIV_FRAC = 2;

    typedef struct packed {
        logic [DIV_INT_W-1:0] div_int;
        logic [FRAC_W-1:0]    div_frac;
    } div_cfg_t;
endpackage

// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: control inputs and tick outputs of the baud generator
interface baud_gen_frac_if
    import baud_gen_frac_pkg::*;
#(
    parameter int DIV_INT_W_P  = DIV_INT_W,
    parameter int FRAC_W_P     = FRAC_W,
    parameter int OVERSAMPLE_P = OVERSAMPLE
);
    logic                            en;
    logic                            div_load;
    logic [DIV_INT_W_P-1:0]          div_int;
    logic [FRAC_W_P-1:0]             div_frac;
    logic                            rx_en;
    logic                            tx_en;
    logic [$clog2(OVERSAMPLE_P)-1:0] os_phase;
    logic                            div_err;

    modport master (output en, div_load, div_int, div_frac,
                    input  rx_en, tx_en, os_phase, div_err);
    modport slave  (input  en, div_load, div_int, div_frac,
                    output rx_en, tx_en, os_phase, div_err);
endinterface

// File: rtl/baud_gen_frac_tick_div.sv
// baud_gen_frac_tick_div: fractional period counter with shadowed divisor; emits the raw tick
module baud_gen_frac_tick_div
    import baud_gen_frac_pkg::*;
#(
    parameter int W      = DIV_INT_W,
    parameter int F      = FRAC_W,
    parameter int D_INT  = DEF_DIV_INT,
    parameter int D_FRAC = DEF_DIV_FRAC
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_int,
    input  logic [F-1:0] div_frac,
    output logic         tick
);
    logic [W-1:0] cnt, act_int, sh_int, nx_int;
    logic [F-1:0] acc, act_frac, sh_frac, nx_frac;
    logic [F:0]   sum;
    logic         pend;

    // A load on the same edge as a reload overrides any pending shadow value
    always_comb begin
        nx_int  = load ? div_int : pend ? sh_int : act_int;
        nx_frac = load ? div_frac : pend ? sh_frac : act_frac;
        sum     = {1'b0, acc} + {1'b0, nx_frac};
        tick    = en && cnt == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= W'(D_INT - 1);
            acc      <= '0;
            act_int  <= W'(D_INT);
            act_frac <= F'(D_FRAC);
            sh_int   <= W'(D_INT);
            sh_frac  <= F'(D_FRAC);
            pend     <= 1'b0;
        end else begin
            if (!en || tick) begin
                act_int  <= nx_int;
                act_frac <= nx_frac;
                pend     <= 1'b0;
            end else if (load) begin
                sh_int  <= div_int;
                sh_frac <= div_frac;
                pend    <= 1'b1;
            end
            cnt <= !en ? nx_int - W'(1) : tick ? nx_int - W'(1) + W'(sum[F]) : cnt - W'(1);
            acc <= !en ? '0 : tick ? sum[F-1:0] : acc;
        end
    end
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: UART oversample/bit tick generator with fractional divider
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter int DIV_INT_W_P    = DIV_INT_W,
    parameter int FRAC_W_P       = FRAC_W,
    parameter int OVERSAMPLE_P   = OVERSAMPLE,
    parameter int DEF_DIV_INT_P  = DEF_DIV_INT,
    parameter int DEF_DIV_FRAC_P = DEF_DIV_FRAC
)(
    input logic            clk,
    input logic            rst_n,
    baud_gen_frac_if.slave bus
);
    localparam int OSW = $clog2(OVERSAMPLE_P);

    logic           fire;
    logic [OSW-1:0] os_cnt;

    baud_gen_frac_tick_div #(
        .W(DIV_INT_W_P), .F(FRAC_W_P), .D_INT(DEF_DIV_INT_P), .D_FRAC(DEF_DIV_FRAC_P)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .load     (bus.div_load && bus.div_int > DIV_INT_W_P'(1)),
        .div_int  (bus.div_int),
        .div_frac (bus.div_frac),
        .tick     (fire)
    );

    // os_cnt wraps naturally since OVERSAMPLE is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt      <= '0;
            bus.rx_en   <= 1'b0;
            bus.tx_en   <= 1'b0;
            bus.div_err <= 1'b0;
        end else begin
            bus.rx_en <= fire;
            bus.tx_en <= fire && os_cnt == OSW'(OVERSAMPLE_P - 1);
            os_cnt    <= !bus.en ? '0 : fire ? os_cnt + OSW'(1) : os_cnt;
            if (bus.div_load)
                bus.div_err <= bus.div_int < DIV_INT_W_P'(2);
        end
    end

    assign bus.os_phase = os_cnt;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: table-driven, hand-written and randomized checks against an event-level model
module tb_baud_gen_frac;
    import baud_gen_frac_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    baud_gen_frac_if bus();
    baud_gen_frac dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the absolute edge number of the next tick
    int  m_int, m_frac, p_int, p_frac, acc, next_tick, phase, k;
    bit  p_v, idle, err, e_rx, e_tx;

    task automatic model_reset();
        m_int = DEF_DIV_INT; m_frac = DEF_DIV_FRAC; p_v = 0; acc = 0;
        phase = 0; idle = 1; err = 0; e_rx = 0; e_tx = 0;
    endtask

    task automatic model_step(input bit en, input bit ld, input int di, input int df);
        bit ok;
        int s;
        ok = ld && di >= 2;
        if (ld) err = di < 2;
        e_rx = 0; e_tx = 0;
        if (!en) begin
            if (ok) begin m_int = di; m_frac = df; end
            else if (p_v) begin m_int = p_int; m_frac = p_frac; end
            p_v = 0; acc = 0; phase = 0; idle = 1;
        end else if (idle) begin
            idle = 0;
            next_tick = k + m_int - 1;
            if (ok) begin p_v = 1; p_int = di; p_frac = df; end
        end else if (k == next_tick) begin
            if (ok) begin m_int = di; m_frac = df; end
            else if (p_v) begin m_int = p_int; m_frac = p_frac; end
            p_v = 0;
            s = acc + m_frac;
            next_tick = k + m_int + (s >= 16 ? 1 : 0);
            acc = s % 16;
            e_rx = 1;
            e_tx = phase == OVERSAMPLE - 1;
            phase = (phase + 1) % OVERSAMPLE;
        end else if (ok) begin
            p_v = 1; p_int = di; p_frac = df;
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        cyc++;
        k++;
        if (!rst_n) model_reset();
        else model_step(bus.en, bus.div_load, int'(bus.div_int), int'(bus.div_frac));
        #1;
        chk("model", int'({bus.rx_en, bus.tx_en, bus.os_phase, bus.div_err}),
            int'({e_rx, e_tx, 4'(phase), err}));
    end

    task automatic load(input div_cfg_t c);
        @(negedge clk);
        bus.div_load = 1'b1; bus.div_int = c.div_int; bus.div_frac = c.div_frac;
        @(negedge clk);
        bus.div_load = 1'b0;
    endtask

    task automatic wait_tx(output int t);
        t = -100000;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (bus.tx_en) begin t = cyc; break; end
        end
    endtask

    task automatic count_to_rx(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.rx_en) begin n = i; break; end
        end
    endtask

    typedef struct {
        int di;
        int df;
        int exp_tx;
        bit exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0, t1, n;
        vecs[0] = '{27, 2, 434, 0};
        vecs[1] = '{10, 0, 160, 0};
        vecs[2] = '{10, 8, 168, 0};
        vecs[3] = '{1, 0, 168, 1};
        vecs[4] = '{5, 0, 80, 0};
        vecs[5] = '{5, 3, 83, 0};
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_int = '0; bus.div_frac = '0;

        repeat (3) @(negedge clk);
        chk("reset_out", int'({bus.rx_en, bus.tx_en, bus.os_phase, bus.div_err}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        count_to_rx(n);
        chk("first_rx_default", n, 27);

        for (int i = 0; i < 6; i++) begin
            load('{DIV_INT_W'(vecs[i].di), FRAC_W'(vecs[i].df)});
            wait_tx(t0); wait_tx(t0);
            wait_tx(t0); wait_tx(t1);
            chk($sformatf("tx_period[%0d]", i), t1 - t0, vecs[i].exp_tx);
            chk($sformatf("div_err[%0d]", i), int'(bus.div_err), int'(vecs[i].exp_err));
        end

        n = 0;
        for (int i = 0; i < 500 && bus.os_phase != 4'd7; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_phase7", int'(bus.os_phase), 7);
        @(negedge clk);
        bus.en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_out", int'({bus.rx_en, bus.tx_en, bus.os_phase}), 0);
        end
        @(negedge clk);
        bus.en = 1'b1;
        count_to_rx(n);
        chk("first_rx_reenable", n, 5);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.en = $urandom_range(0, 19) != 0;
            bus.div_load = $urandom_range(0, 29) == 0;
            bus.div_int = DIV_INT_W'($urandom_range(0, 12));
            bus.div_frac = FRAC_W'($urandom);
        end
        @(negedge clk);
        bus.div_load = 1'b0; bus.en = 1'b1;

        load('{DIV_INT_W'(1), FRAC_W'(0)});
        for (int i = 0; i < 500 && bus.os_phase == '0; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_err", int'(bus.div_err), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", int'({bus.rx_en, bus.tx_en, bus.os_phase, bus.div_err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_to_rx(n);
        chk("first_rx_after_reset", n, 27);
        wait_tx(t0); wait_tx(t1);
        chk("tx_period_after_reset", t1 - t0, 434);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
